// File: rtl/decoder_pkg.sv
// Shared definitions for the sequential 3-to-8 decoder: widths, FSM encoding
// and the one-hot helper used when a code is loaded onto the output.
package decoder_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;
    localparam int HOLD_W = 8;
    localparam int GAP_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } dec_state_e;

    function automatic logic [OUT_W-1:0] one_hot(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] word;
        word       = '0;
        word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/decoder_38_seq_if.sv
// Code-in / one-hot-out bundle between a code producer and decoder_38_seq.
interface decoder_38_seq_if;

    logic                          clr;
    logic                          in_valid;
    logic [decoder_pkg::CODE_W-1:0] in_code;
    logic                          in_ready;
    logic [decoder_pkg::OUT_W-1:0]  y;
    logic                          out_active;
    logic                          done;

    modport master (
        output clr, in_valid, in_code,
        input  in_ready, y, out_active, done
    );

    modport slave (
        input  clr, in_valid, in_code,
        output in_ready, y, out_active, done
    );

endinterface

// File: rtl/dec_code_fifo.sv
// Two-entry in-order code queue; a push and a pop on the same edge both land,
// and clr empties it with priority over everything else.
module dec_code_fifo
    import decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] din,
    output logic [CODE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    logic [CODE_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/decoder_38_seq.sv
// Sequential 3-to-8 decoder: queued codes are driven one-hot on y for
// HOLD_CYCLES clocks, followed by GAP_CYCLES all-zero clocks.
module decoder_38_seq
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    decoder_38_seq_if.slave bus
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("decoder_38_seq: HOLD_CYCLES=%0d outside 1..255", HOLD_CYCLES);
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("decoder_38_seq: GAP_CYCLES=%0d outside 1..15", GAP_CYCLES);
    end

    dec_state_e        state_q;
    dec_state_e        state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [OUT_W-1:0]  y_q;
    logic [CODE_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // in_ready comes straight from the queue occupancy register, never from in_valid
    assign push = bus.in_valid && !full && !bus.clr;
    assign pop  = (state_q == IDLE) && !empty && !bus.clr;

    dec_code_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .push  (push),
        .pop   (pop),
        .din   (bus.in_code),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (bus.clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty) state_d = DRIVE;
            DRIVE:   if (hold_cnt_q == '0) state_d = GAP;
            GAP:     if (gap_cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output word and dwell counters advance alongside the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q        <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else if (bus.clr) begin
            y_q        <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        y_q        <= one_hot(head);
                        hold_cnt_q <= HOLD_W'(HOLD_CYCLES - 1);
                    end
                end
                DRIVE: begin
                    if (hold_cnt_q == '0) begin
                        y_q       <= '0;
                        gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    y_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.y          = y_q;
        bus.out_active = (state_q == DRIVE);
        bus.done       = (state_q == DRIVE) && (hold_cnt_q == '0);
        bus.in_ready   = !full;
    end

endmodule

// File: tb/tb_decoder_38_seq.sv
// Drives a default-parameter and a HOLD=1/GAP=1 decoder with identical stimulus
// and compares both against a slot-position reference model every cycle.
module tb_decoder_38_seq;

    logic clk;
    logic rst_n;

    decoder_38_seq_if if_a ();
    decoder_38_seq_if if_b ();

    decoder_38_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    decoder_38_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;

    // Reference model: a code occupies a slot of HOLD+GAP cycles, position
    // counted from the edge it leaves the queue; the queue is a plain array.
    int hold_p [2];
    int gap_p  [2];
    int mq     [2][2];
    int mcount [2];
    bit busy   [2];
    int pos    [2];
    int cur    [2];
    bit pushed [2];

    logic       drv_valid;
    logic [2:0] drv_code;
    logic       drv_clr;
    bit         seen7;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mcount[i] = 0;
            busy[i]   = 1'b0;
            pos[i]    = 0;
            pushed[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input int i);
        bit do_pop;
        bit do_push;
        pushed[i] = 1'b0;
        if (drv_clr) begin
            mcount[i] = 0;
            busy[i]   = 1'b0;
            return;
        end
        do_pop  = !busy[i] && (mcount[i] > 0);
        do_push = drv_valid && (mcount[i] < 2);
        if (busy[i]) begin
            pos[i]++;
            if (pos[i] == hold_p[i] + gap_p[i]) busy[i] = 1'b0;
        end
        if (do_pop) begin
            cur[i]    = mq[i][0];
            mq[i][0]  = mq[i][1];
            mcount[i]--;
            busy[i]   = 1'b1;
            pos[i]    = 0;
        end
        if (do_push) begin
            mq[i][mcount[i]] = int'(drv_code);
            mcount[i]++;
            pushed[i] = 1'b1;
        end
    endtask

    function automatic logic [7:0] expY(input int i);
        if (busy[i] && pos[i] < hold_p[i]) return 8'(1 << cur[i]);
        return 8'h00;
    endfunction

    task automatic compareAll();
        logic [7:0] ey_a;
        logic [7:0] ey_b;
        ey_a = expY(0);
        ey_b = expY(1);
        checkOutput("y_a",        32'(if_a.y),          32'(ey_a));
        checkOutput("active_a",   32'(if_a.out_active), 32'(ey_a != 8'h00));
        checkOutput("done_a",     32'(if_a.done),       32'(busy[0] && pos[0] == hold_p[0] - 1));
        checkOutput("ready_a",    32'(if_a.in_ready),   32'(mcount[0] < 2));
        checkOutput("y_b",        32'(if_b.y),          32'(ey_b));
        checkOutput("active_b",   32'(if_b.out_active), 32'(ey_b != 8'h00));
        checkOutput("done_b",     32'(if_b.done),       32'(busy[1] && pos[1] == hold_p[1] - 1));
        checkOutput("ready_b",    32'(if_b.in_ready),   32'(mcount[1] < 2));
        checkOutput("onehot0_b",  32'($onehot0(if_b.y)), 32'd1);
        if (if_a.y == 8'h80) seen7 = 1'b1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c, input logic cl);
        @(negedge clk);
        drv_valid     = v;
        drv_code      = c;
        drv_clr       = cl;
        if_a.in_valid = v;
        if_a.in_code  = c;
        if_a.clr      = cl;
        if_b.in_valid = v;
        if_b.in_code  = c;
        if_b.clr      = cl;
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        int idx;
        int budget;
        vectors     = 0;
        miscompares = 0;
        seen7       = 1'b0;
        hold_p[0] = 4;  gap_p[0] = 1;
        hold_p[1] = 1;  gap_p[1] = 1;
        drv_valid = 1'b0; drv_code = 3'd0; drv_clr = 1'b0;
        if_a.in_valid = 1'b0; if_a.in_code = 3'd0; if_a.clr = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_code = 3'd0; if_b.clr = 1'b0;
        modelReset();

        // Reset state
        rst_n = 1'b0;
        #12;
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Single code 5, first acceptance right after reset release
        applyStimulus(1'b1, 3'd5, 1'b0);
        idleCycles(10);

        // Walk codes 0..7 back-to-back, advancing only on acceptance by the default block
        idx    = 0;
        budget = 0;
        while ((idx < 8 || busy[0] || mcount[0] > 0) && budget < 120) begin
            applyStimulus(idx < 8, 3'(idx), 1'b0);
            if (pushed[0]) idx++;
            budget++;
        end
        checkOutput("walk_done", 32'(idx), 32'd8);
        idleCycles(3);

        // Randomized traffic with occasional flushes
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 39) == 0));
        end
        idleCycles(12);

        // Asynchronous reset in the middle of driving code 2
        applyStimulus(1'b1, 3'd2, 1'b0);
        budget = 0;
        while (expY(0) != 8'h04 && budget < 20) begin
            idleCycles(1);
            budget++;
        end
        idleCycles(1);
        checkOutput("drive_before_rst", 32'(expY(0)), 32'h04);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        compareAll();
        checkOutput("rst_async_y", 32'(if_a.y), 32'h00);
        rst_n = 1'b1;
        idleCycles(8);

        // Flush with two codes queued while driving, plus a simultaneous push of 7
        seen7 = 1'b0;
        applyStimulus(1'b1, 3'd1, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0);
        applyStimulus(1'b1, 3'd3, 1'b0);
        checkOutput("clr_pre_count", 32'(mcount[0]), 32'd2);
        applyStimulus(1'b1, 3'd7, 1'b1);
        checkOutput("clr_y_zero", 32'(if_a.y), 32'h00);
        checkOutput("clr_ready", 32'(if_a.in_ready), 32'd1);
        idleCycles(20);
        checkOutput("clr_no_code7", 32'(seen7), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_38_seq.md
DECODER_38_SEQ -- requirements
Module: decoder_38_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of clocks each one-hot word is driven; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 1, number of all-zero clocks inserted after each drive window; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port clr  input  1  synchronous flush of queue and output, active-high.
REQ-006 Port in_valid  input  1  code present on `in_code`.
REQ-007 Port in_code  input  3  binary code to decode, 0..7.
REQ-008 Port in_ready  output  1  block can accept a code this cycle.
REQ-009 Port y  output  8  registered one-hot decode (y[k]=1 for code k), or all zero.
REQ-010 Port out_active  output  1  high while `y` is driving a code.
REQ-011 Port done  output  1  single-cycle pulse on the last drive cycle of each code.

Function
REQ-012 Codes are accepted on a rising edge where in_valid=1 and in_ready=1, then stored in a 2-entry in-order queue.
REQ-013 in_ready shall be 1 exactly when the queue holds fewer than 2 entries; it is a registered output, not a function of in_valid.
REQ-014 FSM states: IDLE, DRIVE, GAP.
REQ-015 IDLE: if the queue is non-empty, pop the head, load y=1<<code, load the hold counter with HOLD_CYCLES-1, and go to DRIVE; otherwise stay with y=0.
REQ-016 DRIVE: hold y and out_active=1. When the hold counter reaches 0, assert done for that cycle, then on the next edge clear y and load the gap counter with GAP_CYCLES-1, entering GAP. Otherwise decrement the counter.
REQ-017 GAP: y=0 and out_active=0. When the gap counter reaches 0, go to IDLE; otherwise decrement.
REQ-018 Latency: a code accepted into an empty queue on edge N while in IDLE appears on y after edge N+1, and is held for exactly HOLD_CYCLES cycles.
REQ-019 Code throughput with a continuously full queue: one code per HOLD_CYCLES+GAP_CYCLES+1 cycles.
REQ-020 A push and a pop on the same edge shall both take effect; the occupancy is unchanged and order is preserved.
REQ-021 in_valid while in_ready=0 shall be ignored; no queue entry changes.
REQ-022 y shall never have more than one bit set.
REQ-023 y shall be 0 whenever out_active=0.
REQ-024 clr=1 on an edge empties the queue, sets y=0, out_active=0, done=0, and state IDLE. A simultaneous push is discarded; clr takes priority over all other events.
REQ-025 Counter widths: hold counter 8 bits, gap counter 4 bits; no wrap-around occurs within legal parameter ranges.

Reset
REQ-026 While rst_n=0, asynchronously: y=0, out_active=0, done=0, in_ready=1, queue empty, state IDLE, counters 0.
REQ-027 Reset asserted mid-DRIVE shall clear y immediately without waiting for a clock edge, and the interrupted code shall be lost.
REQ-028 The first acceptance after reset release shall be possible on the first rising edge with rst_n=1.

Structure
REQ-029 Shared package decoder_pkg holds the FSM state encoding (IDLE, DRIVE, GAP), CODE_W=3, OUT_W=8, and the counter widths.
REQ-030 The 2-entry queue shall be a separate sub-module dec_code_fifo (data, push, pop, clr, full, empty); the FSM and output registers stay in decoder_38_seq.
REQ-031 An out-of-range HOLD_CYCLES or GAP_CYCLES shall be flagged at elaboration.

Verification
REQ-032 Reset release, push code 5 once (defaults): y=8'b0010_0000 for exactly 4 cycles starting 2 edges after acceptance, done high on the 4th, then y=0 for 1 cycle.
REQ-033 Push codes 0..7 back-to-back holding in_valid: in_ready drops after 2 entries, y walks 01,02,..,80 in order, each 4 cycles, spaced 6 cycles apart, no code lost.
REQ-034 Queue at 1 entry, push 3 on the same edge the FSM pops 6: occupancy stays 1, y=0x40 then later 0x08.
REQ-035 Pulse rst_n low mid-DRIVE with y=0x04: y=0 immediately, in_ready=1, queue empty, no done pulse.
REQ-036 clr asserted with 2 codes queued and in DRIVE, with a simultaneous push of 7: next cycle y=0, state IDLE, queue empty, code 7 never appears.
REQ-037 HOLD_CYCLES=1, GAP_CYCLES=1, push 2: y=0x04 for one cycle with done on that same cycle; every cycle checks that y is one-hot or zero.
